// File: rtl/pbit_pkg.sv
// Shared types and default sizing for the p-bit stream collector slice.
package pbit_pkg;

    localparam int unsigned PBIT_W         = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned WIN_LEN_DEF    = 256;

    typedef logic [PBIT_W-1:0] pbit_word_t;

endpackage

// File: rtl/pbit_stream_collector_if.sv
// Stream-in / host-read / monitor bundle for pbit_stream_collector.
interface pbit_stream_collector_if
    import pbit_pkg::*;
#(
    parameter int unsigned WIN_LEN = WIN_LEN_DEF
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

    logic             bit_in;
    logic             bit_valid;
    logic             off;
    logic             rd_en;
    logic             ovf_clr;
    pbit_word_t       rd_data;
    logic             rd_valid;
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow;
    logic [CNT_W-1:0] ones_count;
    logic             window_done;

    modport master (
        output bit_in, bit_valid, off, rd_en, ovf_clr,
        input  rd_data, rd_valid, fifo_empty, fifo_full, overflow, ones_count, window_done
    );

    modport slave (
        input  bit_in, bit_valid, off, rd_en, ovf_clr,
        output rd_data, rd_valid, fifo_empty, fifo_full, overflow, ones_count, window_done
    );

endinterface

// File: rtl/pbit_sync_fifo.sv
// Circular word FIFO with registered read port and registered full/empty flags.
module pbit_sync_fifo
    import pbit_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pbit_word_t push_data,
    input  logic       pop,
    output pbit_word_t rd_data,
    output logic       rd_valid,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    pbit_word_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    pbit_word_t    rd_data_q;
    logic          rd_valid_q, full_q, empty_q;
    logic          pop_eff, push_eff;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
    always_comb begin
        pop_eff  = pop && !empty_q;
        push_eff = push && (!full_q || pop_eff);
        count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_eff) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem[rd_ptr_q];
            end
            rd_valid_q <= pop_eff;
            count_q    <= count_d;
            full_q     <= (count_d == CW'(DEPTH));
            empty_q    <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr_q] <= push_data;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/pbit_stream_collector.sv
// Deserializes the MSB-first p-bit stream into a FIFO and tracks overflow.
// Bias monitor (ones per window) is built only when PBIT_BIAS_MON_EN is defined.
module pbit_stream_collector
    import pbit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned WIN_LEN    = WIN_LEN_DEF
) (
    input logic                    clk,
    input logic                    rst,
    pbit_stream_collector_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

    logic [PBIT_W-2:0] shift_q;
    logic [2:0]        bit_cnt_q;
    logic              accept, push, drop;
    pbit_word_t        push_data, rd_data;
    logic              rd_valid, full, empty;
    logic              overflow_q;

    assign accept    = bus.bit_valid && !bus.off;
    assign push      = accept && (bit_cnt_q == 3'd7);
    assign push_data = {shift_q, bus.bit_in};
    // Full implies non-empty, so any rd_en pops and makes room.
    assign drop      = push && full && !bus.rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (bus.off) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (bus.bit_valid) begin
            shift_q   <= push_data[PBIT_W-2:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    pbit_sync_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (bus.rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty)
    );

    assign bus.rd_data    = rd_data;
    assign bus.rd_valid   = rd_valid;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.overflow   = overflow_q;

`ifdef PBIT_BIAS_MON_EN
    localparam int unsigned WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    logic [WW-1:0]    win_cnt_q;
    logic [CNT_W-1:0] ones_acc_q, ones_count_q;
    logic             window_done_q;

    // Window advances only on accepted bits, so off freezes it without clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q     <= '0;
            ones_acc_q    <= '0;
            ones_count_q  <= '0;
            window_done_q <= 1'b0;
        end else begin
            window_done_q <= 1'b0;
            if (accept) begin
                if (win_cnt_q == WW'(WIN_LEN - 1)) begin
                    ones_count_q  <= ones_acc_q + CNT_W'(bus.bit_in);
                    window_done_q <= 1'b1;
                    win_cnt_q     <= '0;
                    ones_acc_q    <= '0;
                end else begin
                    win_cnt_q  <= win_cnt_q + 1'b1;
                    ones_acc_q <= ones_acc_q + CNT_W'(bus.bit_in);
                end
            end
        end
    end

    assign bus.ones_count  = ones_count_q;
    assign bus.window_done = window_done_q;
`else
    assign bus.ones_count  = '0;
    assign bus.window_done = 1'b0;
`endif

endmodule

// File: tb/tb_pbit_stream_collector.sv
// Directed bench for pbit_stream_collector; expectations hand-computed per step.
module tb_pbit_stream_collector;
    import pbit_pkg::*;

    localparam int unsigned WIN = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wd_pulses = 0;
    logic [31:0] last_ones = '0;

    always #5 clk = ~clk;

    pbit_stream_collector_if #(.WIN_LEN(WIN)) bus ();

    pbit_stream_collector #(
        .FIFO_DEPTH(8),
        .WIN_LEN   (WIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.window_done === 1'b1) begin
            wd_pulses++;
            last_ones = 32'(bus.ones_count);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        step();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_read();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'h0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
        chk({tag, "_empty"}, 32'(bus.fifo_empty), 32'h1);
        chk({tag, "_full"}, 32'(bus.fifo_full), 32'h0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'h0);
        chk({tag, "_ones"}, 32'(bus.ones_count), 32'h0);
        chk({tag, "_wdone"}, 32'(bus.window_done), 32'h0);
    endtask

    initial begin
        logic [7:0] w;
        bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.off = 1'b0;
        bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
        step(); step();
        chk_reset("reset");
        rst = 1'b0;
        step();

        // Basic word assembly and pop.
        send_word(8'hA5);
        chk("a5_not_empty", 32'(bus.fifo_empty), 32'h0);
        do_read();
        chk("a5_rd_valid", 32'(bus.rd_valid), 32'h1);
        chk("a5_rd_data", 32'(bus.rd_data), 32'hA5);
        chk("a5_empty_after", 32'(bus.fifo_empty), 32'h1);
        step();
        chk("a5_valid_pulse", 32'(bus.rd_valid), 32'h0);

        // Partial word discarded by off.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        bus.off = 1'b1; step(); bus.off = 1'b0;
        chk("off_still_empty", 32'(bus.fifo_empty), 32'h1);
        send_word(8'h3C);
        do_read();
        chk("off_word", 32'(bus.rd_data), 32'h3C);
        chk("off_empty_after", 32'(bus.fifo_empty), 32'h1);

        // Fill, overflow, drain in order, clear.
        for (int i = 0; i < 8; i++) send_word(8'(i));
        chk("fill_full", 32'(bus.fifo_full), 32'h1);
        chk("fill_no_ovf", 32'(bus.overflow), 32'h0);
        send_word(8'hFF);
        chk("ovf_set", 32'(bus.overflow), 32'h1);
        chk("ovf_still_full", 32'(bus.fifo_full), 32'h1);
        for (int i = 0; i < 8; i++) begin
            do_read();
            chk($sformatf("drain_%0d", i), 32'(bus.rd_data), 32'(i));
        end
        chk("drain_empty", 32'(bus.fifo_empty), 32'h1);
        chk("ovf_sticky", 32'(bus.overflow), 32'h1);
        bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 32'h0);

        // Push into full FIFO coinciding with pop.
        for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i));
        w = 8'h99;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        bus.rd_en = 1'b1;
        send_bit(w[0]);
        bus.rd_en = 1'b0;
        chk("pp_rd_valid", 32'(bus.rd_valid), 32'h1);
        chk("pp_oldest", 32'(bus.rd_data), 32'h10);
        chk("pp_full", 32'(bus.fifo_full), 32'h1);
        chk("pp_no_ovf", 32'(bus.overflow), 32'h0);
        for (int i = 1; i < 8; i++) begin
            do_read();
            chk($sformatf("pp_drain_%0d", i), 32'(bus.rd_data), 32'h10 + 32'(i));
        end
        do_read();
        chk("pp_new_word", 32'(bus.rd_data), 32'h99);
        chk("pp_empty", 32'(bus.fifo_empty), 32'h1);

        // Read while empty is ignored.
        do_read();
        chk("empty_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("empty_rd_hold", 32'(bus.rd_data), 32'h99);

        // Asynchronous reset mid-word.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        rst = 1'b0;
        step();
        send_word(8'h5A);
        do_read();
        chk("midrst_clean_word", 32'(bus.rd_data), 32'h5A);

        // Bias monitor: 32 words of 0x0F from a fresh window.
        rst = 1'b1; #1; rst = 1'b0;
        step();
        wd_pulses = 0;
        last_ones = '0;
        for (int i = 0; i < 32; i++) send_word(8'h0F);
        step();
`ifdef PBIT_BIAS_MON_EN
        chk("bias_pulses", 32'(wd_pulses), 32'd1);
        chk("bias_ones", last_ones, 32'd128);
        chk("bias_ones_port", 32'(bus.ones_count), 32'd128);
`else
        chk("bias_pulses", 32'(wd_pulses), 32'd0);
        chk("bias_ones_port", 32'(bus.ones_count), 32'd0);
`endif
        chk("bias_wdone_low", 32'(bus.window_done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
